uart_rx_channel: RTL and testbench

- Receive half of the UART. Oversamples the serial line `rx` on the shared 16x baud tick `S_tick` and deframes 8N1 characters (start bit, data LSB first, stop bit).
- Completed characters go into an internal FIFO that the host drains with a first-word-fall-through read port.
- Flags framing errors and overruns. Mirrors the transmit-side top so the serial link closes in loopback.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_fsm.sv | 110 +++++++++++
 rtl/uart_rx_channel.sv | 104 ++++++++++
 tb/tb_uart_rx_channel.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART receive and transmit halves.
package uart_pkg;

  localparam int N_BIT      = 8;
  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// Serial-line synchroniser and 8N1 deframer running on the 16x oversampling tick.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int N_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick_i,
  input  logic             rx_i,
  output logic [N_BIT-1:0] dout_o,
  output logic             rx_done_tick_o,
  output logic             frame_err_o
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = (N_BIT > 1) ? $clog2(N_BIT) : 1;
  localparam logic [SW-1:0] S_MID       = SW'(START_MID);
  localparam logic [SW-1:0] S_LAST_DATA = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(N_BIT - 1);

  uart_state_e      state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [SW-1:0]    s_q;
  logic [NW-1:0]    n_q;
  logic [N_BIT-1:0] shreg_q;
  logic             done_q;
  logic             ferr_q;

  // Synchroniser, deframing state machine and registered done/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!sync2_q) begin
            s_q     <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick_i) begin
            if (s_q == S_MID) begin
              // A high line at mid start bit was only a glitch.
              if (!sync2_q) begin
                s_q     <= '0;
                n_q     <= '0;
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick_i) begin
            if (s_q == S_LAST_DATA) begin
              s_q     <= '0;
              shreg_q <= {sync2_q, shreg_q[N_BIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick_i) begin
            if (s_q == S_LAST_STOP) begin
              state_q <= IDLE;
              if (sync2_q) begin
                done_q <= 1'b1;
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_o         = shreg_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = ferr_q;

endmodule

// File: rtl/uart_rx_channel.sv
// UART receive channel: deframer feeding a first-word-fall-through FIFO with
// framing-error and overrun pulses.
module uart_rx_channel
  import uart_pkg::*;
#(
  parameter int N_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int ADDR_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_tick,
  input  logic             rx,
  input  logic             rx_rd_en,
  output logic [N_BIT-1:0] rx_rd_data,
  output logic             rx_empty,
  output logic             rx_full,
  output logic             frame_err,
  output logic             overrun_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [N_BIT-1:0]  dout_s;
  logic              rx_done_s;
  logic              push_s;
  logic              pop_s;
  logic              overrun_d;
  logic [ADDR_W:0]   count_d;
  logic              empty_d;
  logic              full_d;

  logic [N_BIT-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              empty_q;
  logic              full_q;
  logic              overrun_q;

  uart_rx_fsm #(
    .N_BIT  (N_BIT),
    .SB_TICK(SB_TICK)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .s_tick_i      (S_tick),
    .rx_i          (rx),
    .dout_o        (dout_s),
    .rx_done_tick_o(rx_done_s),
    .frame_err_o   (frame_err)
  );

  // Push/pop arbitration: a full FIFO still accepts a byte when the same clk pops.
  always_comb begin
    pop_s     = rx_rd_en && !empty_q;
    push_s    = rx_done_s && (!full_q || rx_rd_en);
    overrun_d = rx_done_s && full_q && !rx_rd_en;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
  end

  // FIFO pointers, occupancy flags and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= dout_s;
    end
  end

  assign rx_rd_data  = mem_q[rd_ptr_q];
  assign rx_empty    = empty_q;
  assign rx_full     = full_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_channel.sv
// Directed bench for uart_rx_channel: frames are driven with S_tick every 4 clks
// (64 clks per bit); the stop-bit sample lands 609 clks after the start edge.
module tb_uart_rx_channel;

  logic       clk;
  logic       rst;
  logic       S_tick;
  logic       rx;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun_err;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         fe_cnt;
  int         ov_cnt;
  logic       e609;
  logic       e610;
  logic       e_rst;
  logic [7:0] rd_seen;

  uart_rx_channel #(.N_BIT(8), .SB_TICK(16), .ADDR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .S_tick     (S_tick),
    .rx         (rx),
    .rx_rd_en   (rx_rd_en),
    .rx_rd_data (rx_rd_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    S_tick = (cyc % 4 == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (frame_err)   fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {8'h00, rx_rd_data}, {8'h00, exp});
    check({tag, "_nonempty"}, {15'h0, rx_empty}, 16'h0000);
    rx_rd_en = 1'b1;
    step();
    rx_rd_en = 1'b0;
  endtask

  // One 8N1 frame; rd_at pulses rx_rd_en for one clk, abort_at pulses rst mid-frame.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                            input int rd_at, input int abort_at);
    logic [9:0] bits;
    int idx;
    bits   = {1'b1, data, 1'b0};
    fe_cnt = 0;
    ov_cnt = 0;
    while (cyc % 4 != 0) step();
    rx = bits[0];
    for (int t = 1; t <= 640; t++) begin
      step();
      if (frame_err)   fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (t == 609) e609 = rx_empty;
      if (t == 610) e610 = rx_empty;
      if (t == rd_at) rd_seen = rx_rd_data;
      if (abort_at >= 0 && t == abort_at + 1) begin
        e_rst    = rx_empty;
        rst      = 1'b0;
        rx       = 1'b1;
        rx_rd_en = 1'b0;
        break;
      end
      rx_rd_en = (t == rd_at);
      rst      = (t == abort_at);
      if (t < 640) begin
        idx = t / 64;
        rx  = (idx == 9) ? (stop_ok || t >= 616) : bits[idx];
      end else begin
        rx = 1'b1;
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
    rst      = 1'b1;
    rx       = 1'b1;
    rx_rd_en = 1'b0;
    S_tick   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_empty", {15'h0, rx_empty}, 16'h0001);
    check("rst_full", {15'h0, rx_full}, 16'h0000);
    check("rst_ferr", {15'h0, frame_err}, 16'h0000);
    check("rst_ovr", {15'h0, overrun_err}, 16'h0000);

    // Single byte and first-word-fall-through latency.
    send_frame(8'hA5, 1'b1, -1, -1);
    check("a5_empty_at_done", {15'h0, e609}, 16'h0001);
    check("a5_empty_after", {15'h0, e610}, 16'h0000);
    check("a5_ferr", fe_cnt[15:0], 16'd0);
    check("a5_ovr", ov_cnt[15:0], 16'd0);
    pop_check("a5_data", 8'hA5);
    check("a5_drained", {15'h0, rx_empty}, 16'h0001);

    // Fill to full, then overrun.
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    send_frame(8'h00, 1'b1, -1, -1);
    check("three_not_full", {15'h0, rx_full}, 16'h0000);
    send_frame(8'h81, 1'b1, -1, -1);
    check("four_full", {15'h0, rx_full}, 16'h0001);
    send_frame(8'h55, 1'b1, -1, -1);
    check("ovr_pulses", ov_cnt[15:0], 16'd1);
    check("ovr_ferr", fe_cnt[15:0], 16'd0);
    check("ovr_still_full", {15'h0, rx_full}, 16'h0001);
    pop_check("fifo0", 8'h3C);
    pop_check("fifo1", 8'hFF);
    pop_check("fifo2", 8'h00);
    pop_check("fifo3", 8'h81);
    check("fifo_empty", {15'h0, rx_empty}, 16'h0001);
    check("fifo_not_full", {15'h0, rx_full}, 16'h0000);

    // Full FIFO with a pop on the exact done clk: no overrun.
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    send_frame(8'h33, 1'b1, -1, -1);
    send_frame(8'h44, 1'b1, -1, -1);
    send_frame(8'h77, 1'b1, 609, -1);
    check("simul_head", {8'h00, rd_seen}, 16'h0011);
    check("simul_ovr", ov_cnt[15:0], 16'd0);
    check("simul_full", {15'h0, rx_full}, 16'h0001);
    pop_check("simul0", 8'h22);
    pop_check("simul1", 8'h33);
    pop_check("simul2", 8'h44);
    pop_check("simul3", 8'h77);
    check("simul_empty", {15'h0, rx_empty}, 16'h0001);

    // Stop bit forced low.
    send_frame(8'h42, 1'b0, -1, -1);
    idle(50);
    check("ferr_pulses", fe_cnt[15:0], 16'd1);
    check("ferr_ovr", ov_cnt[15:0], 16'd0);
    check("ferr_empty_done", {15'h0, e610}, 16'h0001);
    check("ferr_empty", {15'h0, rx_empty}, 16'h0001);

    // Short low glitch on the idle line, then a real byte.
    fe_cnt = 0;
    ov_cnt = 0;
    while (cyc % 4 != 0) step();
    rx = 1'b0;
    repeat (12) step();
    rx = 1'b1;
    idle(100);
    check("glitch_ferr", fe_cnt[15:0], 16'd0);
    check("glitch_ovr", ov_cnt[15:0], 16'd0);
    check("glitch_empty", {15'h0, rx_empty}, 16'h0001);
    send_frame(8'h99, 1'b1, -1, -1);
    check("post_glitch_ready", {15'h0, e610}, 16'h0000);
    pop_check("post_glitch_data", 8'h99);
    check("post_glitch_empty", {15'h0, rx_empty}, 16'h0001);

    // Reset in data bit 4 with one byte queued.
    send_frame(8'hE1, 1'b1, -1, -1);
    check("queued_before_rst", {15'h0, rx_empty}, 16'h0000);
    send_frame(8'hC3, 1'b1, -1, 350);
    check("rst_mid_empty", {15'h0, e_rst}, 16'h0001);
    idle(100);
    check("rst_mid_partial", {15'h0, rx_empty}, 16'h0001);
    check("rst_mid_ferr", fe_cnt[15:0], 16'd0);
    check("rst_mid_ovr", ov_cnt[15:0], 16'd0);
    send_frame(8'h5A, 1'b1, -1, -1);
    check("post_rst_ready", {15'h0, e610}, 16'h0000);
    pop_check("post_rst_data", 8'h5A);
    check("post_rst_empty", {15'h0, rx_empty}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
